// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: command and FSM state
// encodings, data width, and the grant selection helper.
package alu_pkg;

  localparam int DW = 6;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    ROR  = 2'b01,
    NAND = 2'b10,
    RSVD = 2'b11
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // Contention goes to the requester that was not served last when fair,
  // otherwise requester 0 always wins. A lone requester always wins.
  function automatic logic grant_idx(input logic [1:0] valid,
                                     input logic last,
                                     input logic fair);
    if (valid == 2'b11) begin
      return fair ? ~last : 1'b0;
    end
    return valid[1] & ~valid[0];
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 6-bit ALU: add with carry-in, rotate right, NAND.
// The reserved command yields zero.
module alu
  import alu_pkg::*;
(
  input  logic [1:0]    cmd,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sc_i,
  output logic [DW-1:0] rslt,
  output logic          neq
);

  localparam logic [DW-1:0] DW_V = DW[DW-1:0];

  logic [DW-1:0]   amt;
  logic [2*DW-1:0] dbl;

  // Rotating by b is rotating by b modulo the word width.
  assign amt = b % DW_V;
  assign dbl = {a, a} >> amt;
  assign neq = (a != b);

  always_comb begin
    rslt = '0;
    case (alu_cmd_e'(cmd))
      ADD:     rslt = a + b + {{(DW-1){1'b0}}, sc_i};
      ROR:     rslt = dbl[DW-1:0];
      NAND:    rslt = ~(a & b);
      default: rslt = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single ALU: arbitrates, executes one
// operation at a time and returns the result on the owner's lane.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][1:0]      req_cmd,
  input  logic [1:0][DW-1:0]   req_a,
  input  logic [1:0][DW-1:0]   req_b,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [1:0][DW-1:0]   rsp_rslt,
  output logic [1:0]           rsp_zero,
  output logic [1:0]           rsp_neq,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high on the same lane. ready never depends on ready of the other
  // side; valid, once raised by this block, holds until its handshake.

  state_e        state;
  state_e        state_nxt;
  logic          gnt;
  logic          accept;
  logic          rsp_done;
  logic          last_grant;
  logic          owner;
  logic [1:0]    cmd_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] rslt_q;
  logic          zero_q;
  logic          neq_q;
  logic [DW-1:0] alu_rslt;
  logic          alu_neq;

  assign gnt      = grant_idx(req_valid, last_grant, FAIR != 0);
  assign accept   = (state == IDLE) && req_valid[gnt];
  assign rsp_done = (state == RESP) && rsp_ready[owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if ((state == IDLE) && req_valid[gnt]) begin
      req_ready[gnt] = 1'b1;
    end
    if (state == RESP) begin
      rsp_valid[owner] = 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Operands are captured at acceptance so requesters may change them freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else if (accept) begin
      last_grant <= gnt;
      owner      <= gnt;
      cmd_q      <= req_cmd[gnt];
      a_q        <= req_a[gnt];
      b_q        <= req_b[gnt];
    end
  end

  alu u_alu (
    .cmd  (cmd_q),
    .a    (a_q),
    .b    (b_q),
    .sc_i (1'b0),
    .rslt (alu_rslt),
    .neq  (alu_neq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rslt_q <= '0;
      zero_q <= 1'b0;
      neq_q  <= 1'b0;
    end else if (state == EXEC) begin
      rslt_q <= alu_rslt;
      zero_q <= (alu_rslt == '0);
      neq_q  <= alu_neq;
    end
  end

  assign rsp_rslt = {rslt_q, rslt_q};
  assign rsp_zero = {zero_q, zero_q};
  assign rsp_neq  = {neq_q, neq_q};

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: fair instance driven by a vector table and corner
// sequences, plus a fixed-priority instance for the priority check.
module tb_alu_arbiter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][1:0]  req_cmd;
  logic [1:0][5:0]  req_a;
  logic [1:0][5:0]  req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][5:0]  rsp_rslt;
  logic [1:0]       rsp_zero;
  logic [1:0]       rsp_neq;
  logic             busy;
  logic [1:0]       dbg_state;

  logic [1:0]       fp_req_valid;
  logic [1:0]       fp_req_ready;
  logic [1:0][1:0]  fp_req_cmd;
  logic [1:0][5:0]  fp_req_a;
  logic [1:0][5:0]  fp_req_b;
  logic [1:0]       fp_rsp_valid;
  logic [1:0]       fp_rsp_ready;
  logic [1:0][5:0]  fp_rsp_rslt;
  logic [1:0]       fp_rsp_zero;
  logic [1:0]       fp_rsp_neq;
  logic             fp_busy;
  logic [1:0]       fp_dbg_state;

  int total = 0;
  int bad   = 0;

  // {owner, rslt[5:0], zero, neq}
  logic [8:0] exp_q[$];

  typedef struct {
    int         who;
    logic [1:0] cmd;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] rslt;
    logic       zero;
    logic       neq;
  } vec_t;

  vec_t vecs[9];

  alu_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rslt(rsp_rslt),
    .rsp_zero(rsp_zero), .rsp_neq(rsp_neq),
    .busy(busy), .dbg_state(dbg_state)
  );

  alu_arbiter #(.FAIR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid(fp_req_valid), .req_ready(fp_req_ready), .req_cmd(fp_req_cmd),
    .req_a(fp_req_a), .req_b(fp_req_b),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_rslt(fp_rsp_rslt),
    .rsp_zero(fp_rsp_zero), .rsp_neq(fp_rsp_neq),
    .busy(fp_busy), .dbg_state(fp_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // reference ALU: {rslt, zero, neq}
  function automatic logic [7:0] model(input logic [1:0] cmd, input logic [5:0] a,
                                       input logic [5:0] b);
    logic [5:0] r;
    r = '0;
    case (cmd)
      2'b00: r = a + b;
      2'b01: begin
        r = a;
        for (int i = 0; i < int'(b); i++) r = {r[0], r[5:1]};
      end
      2'b10: r = ~(a & b);
      default: r = '0;
    endcase
    return {r, (r == 6'd0), (a != b)};
  endfunction

  function automatic logic [1:0] onehot(input int who);
    return (who != 0) ? 2'b10 : 2'b01;
  endfunction

  // driver tasks (called at a falling edge)
  task automatic drive(input int who, input logic [1:0] cmd, input logic [5:0] a,
                       input logic [5:0] b);
    req_valid[who] = 1'b1;
    req_cmd[who]   = cmd;
    req_a[who]     = a;
    req_b[who]     = b;
  endtask

  // Waits for the grant, records the expectation, returns just after the
  // acceptance edge.
  task automatic accept(input int who, input logic [7:0] exp, input bit drop);
    int n;
    n = 0;
    #1;
    while (!req_ready[who] && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", (n < 10), 1);
    if (n < 10) chk("ready_onehot", req_ready, onehot(who));
    exp_q.push_back({(who != 0), exp});
    @(posedge clk);
    #1;
    if (drop) req_valid[who] = 1'b0;
  endtask

  // scoreboard: waits for the response, compares, optionally stalls, completes it
  task automatic collect(input int who, input int stall, input bit other_ready);
    int n;
    logic [8:0] e;
    @(negedge clk);
    n = 1;
    chk("exec_req_ready", req_ready, 0);
    chk("exec_busy", busy, 1);
    chk("exec_no_rsp", rsp_valid, 0);
    while (!rsp_valid[who] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", n, 2);
    chk("sb_nonempty", (exp_q.size() != 0), 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
    chk("rsp_valid_lane", rsp_valid, onehot(int'(e[8])));
    chk("rsp_rslt", rsp_rslt[who], e[7:2]);
    chk("rsp_rslt_other", rsp_rslt[1-who], e[7:2]);
    chk("rsp_zero", rsp_zero[who], e[1]);
    chk("rsp_neq", rsp_neq[who], e[0]);
    rsp_ready[1-who] = other_ready;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, onehot(who));
      chk("stall_rslt", rsp_rslt[who], e[7:2]);
      chk("stall_req_ready", req_ready, 0);
    end
    rsp_ready[who] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = '0;
    chk("done_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
  endtask

  initial begin : main
    int last_g;
    int g;
    int w;
    int n;
    logic [1:0] c;
    logic [5:0] ra;
    logic [5:0] rb;
    logic [7:0] ex;
    logic [8:0] e;

    vecs[0] = '{0, 2'b00, 6'd60,      6'd5,      6'd1,       1'b0, 1'b1};
    vecs[1] = '{1, 2'b01, 6'b000011,  6'd1,      6'b100001,  1'b0, 1'b1};
    vecs[2] = '{0, 2'b10, 6'h3f,      6'h3f,     6'd0,       1'b1, 1'b0};
    vecs[3] = '{1, 2'b00, 6'd32,      6'd32,     6'd0,       1'b1, 1'b0};
    vecs[4] = '{0, 2'b11, 6'd5,       6'd7,      6'd0,       1'b1, 1'b1};
    vecs[5] = '{1, 2'b01, 6'b000001,  6'd7,      6'b100000,  1'b0, 1'b1};
    vecs[6] = '{0, 2'b10, 6'h2a,      6'h15,     6'h3f,      1'b0, 1'b1};
    vecs[7] = '{1, 2'b00, 6'd0,       6'd0,      6'd0,       1'b1, 1'b0};
    vecs[8] = '{0, 2'b01, 6'b101100,  6'd0,      6'b101100,  1'b0, 1'b1};

    rst_n = 1'b0;
    req_valid = '0; req_cmd = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    fp_req_valid = '0; fp_req_cmd = '0; fp_req_a = '0; fp_req_b = '0; fp_rsp_ready = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rslt", rsp_rslt, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_neq", rsp_neq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fp_rsp_valid", fp_rsp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_busy", busy, 0);

    // both valid straight after reset: requester 0 first, then 1
    drive(0, 2'b10, 6'h3f, 6'h3f);
    drive(1, 2'b10, 6'h00, 6'h00);
    accept(0, {6'h00, 1'b1, 1'b0}, 1'b1);
    collect(0, 0, 1'b0);
    #1;
    chk("rr_second_grant", req_ready, 2'b10);
    accept(1, {6'h3f, 1'b0, 1'b0}, 1'b1);
    collect(1, 0, 1'b0);
    last_g = 1;

    // vector table
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].who, vecs[i].cmd, vecs[i].a, vecs[i].b);
      accept(vecs[i].who, {vecs[i].rslt, vecs[i].zero, vecs[i].neq}, 1'b1);
      collect(vecs[i].who, 0, 1'b0);
      last_g = vecs[i].who;
    end

    // random single-requester traffic
    for (int i = 0; i < 8; i++) begin
      w  = $urandom_range(0, 1);
      c  = 2'($urandom_range(0, 3));
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      drive(w, c, ra, rb);
      accept(w, model(c, ra, rb), 1'b1);
      collect(w, 0, 1'b0);
      last_g = w;
    end

    // contention with a stalled owner; the other lane's rsp_ready is ignored
    g = (last_g != 0) ? 0 : 1;
    drive(0, 2'b00, 6'd10, 6'd20);
    drive(1, 2'b01, 6'd5, 6'd2);
    #1;
    chk("stall_grant", req_ready, onehot(g));
    accept(g, model(req_cmd[g], req_a[g], req_b[g]), 1'b1);
    collect(g, 5, 1'b1);
    #1;
    chk("after_hs_grant", req_ready, onehot(1 - g));
    accept(1 - g, model(req_cmd[1-g], req_a[1-g], req_b[1-g]), 1'b1);
    collect(1 - g, 0, 1'b0);

    // reset in RESP drops the operation and restores last_grant
    drive(1, 2'b00, 6'd1, 6'd2);
    accept(1, model(2'b00, 6'd1, 6'd2), 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_resp", rsp_valid, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", rsp_valid, 0);
    chk("rst_resp_busy", busy, 0);
    chk("rst_resp_rslt", rsp_rslt, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    drive(0, 2'b10, 6'h0f, 6'h33);
    drive(1, 2'b00, 6'd3, 6'd4);
    #1;
    chk("rst_grant_req0", req_ready, 2'b01);
    accept(0, model(2'b10, 6'h0f, 6'h33), 1'b1);
    collect(0, 0, 1'b0);
    req_valid[1] = 1'b0;

    // reset in EXEC
    @(negedge clk);
    drive(0, 2'b10, 6'd1, 6'd2);
    accept(0, model(2'b10, 6'd1, 6'd2), 1'b1);
    @(negedge clk);
    chk("pre_rst_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_exec_busy", busy, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp_after_exec_rst", rsp_valid, 0);
    end

    // fixed priority: both lanes continuously valid
    fp_req_valid = 2'b11;
    fp_rsp_ready = 2'b11;
    fp_req_cmd[1] = 2'b10; fp_req_a[1] = 6'h11; fp_req_b[1] = 6'h22;
    fp_req_cmd[0] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fp_req_a[0] = 6'(k * 9);
      fp_req_b[0] = 6'(k + 3);
      n = 0;
      #1;
      while (fp_req_ready == 2'b00 && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("fp_accept_timeout", (n < 10), 1);
      chk("fp_grant", fp_req_ready, 2'b01);
      exp_q.push_back({1'b0, model(2'b00, fp_req_a[0], fp_req_b[0])});
      @(posedge clk);
      n = 0;
      @(negedge clk);
      while (fp_rsp_valid == 2'b00 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("fp_rsp_valid", fp_rsp_valid, 2'b01);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
      chk("fp_rslt", fp_rsp_rslt[0], e[7:2]);
      chk("fp_zero", fp_rsp_zero[0], e[1]);
    end
    fp_req_valid = '0;
    fp_rsp_ready = '0;

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
